seq_gen_1010_tx: RTL



---
 rtl/seq1010_pkg.sv | 11 +
 rtl/seq_match_model.sv | 57 +++++
 rtl/seq_gen_1010_tx.sv | 133 +++++++++++++
 3 files changed

// File: rtl/seq1010_pkg.sv
// Shared constants for the 1010 transmitter and detector benches:
// the tracked pattern and the transmitter state encoding.
package seq1010_pkg;

  localparam logic [3:0] PAT_1010 = 4'b1010;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/seq_match_model.sv
// Reference pattern counter over a serial bit stream; OVERLAP selects whether
// a match may share bits with the next one.
module seq_match_model
  import seq1010_pkg::*;
#(
  parameter logic [3:0] PATTERN = PAT_1010,
  parameter int          CNT_W   = 8,
  parameter bit          OVERLAP = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_bit_vld,
  input  logic             i_bit_in,
  output logic [CNT_W-1:0] o_cnt
);

  logic [2:0]       r_hist;
  logic [1:0]       r_fill;
  logic [CNT_W-1:0] r_cnt;
  logic             w_match;

  // A match needs three history bits plus the incoming one.
  always_comb begin
    w_match = (r_fill == 2'd3) && ({r_hist, i_bit_in} == PATTERN);
  end

  // History, fill level and saturating match counter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hist <= 3'd0;
      r_fill <= 2'd0;
      r_cnt  <= '0;
    end else if (i_clr) begin
      r_hist <= 3'd0;
      r_fill <= 2'd0;
      r_cnt  <= '0;
    end else if (i_bit_vld) begin
      if (w_match && (r_cnt != {CNT_W{1'b1}})) begin
        r_cnt <= r_cnt + 1'b1;
      end
      // Non-overlapping matching restarts from an empty history.
      if (w_match && !OVERLAP) begin
        r_hist <= 3'd0;
        r_fill <= 2'd0;
      end else begin
        r_hist <= {r_hist[1:0], i_bit_in};
        if (r_fill != 2'd3) begin
          r_fill <= r_fill + 2'd1;
        end
      end
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/seq_gen_1010_tx.sv
// Serial MSB-first frame transmitter with embedded overlapping and
// non-overlapping 1010 match counters for checking detector outputs.
module seq_gen_1010_tx
  import seq1010_pkg::*;
#(
  parameter int          DATA_W  = 16,
  parameter int          LEN_W   = 5,
  parameter int          CNT_W   = 8,
  parameter logic [3:0]  PATTERN = PAT_1010
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_data_in,
  input  logic [LEN_W-1:0]  i_len,
  output logic              o_ser_out,
  output logic              o_ser_valid,
  output logic              o_busy,
  output logic              o_done,
  output logic [CNT_W-1:0]  o_exp_cnt_ol,
  output logic [CNT_W-1:0]  o_exp_cnt_nol
);

  logic [1:0]        r_state;
  logic [DATA_W-1:0] r_shift;
  logic [LEN_W-1:0]  r_bit_cnt;
  logic              r_ser_out;
  logic              r_ser_valid;
  logic              r_busy;
  logic              r_done;
  logic [LEN_W-1:0]  w_len;
  logic              w_accept;

  // Clamp the requested length to the data width and detect acceptance.
  always_comb begin
    if (i_len > LEN_W'(DATA_W)) begin
      w_len = LEN_W'(DATA_W);
    end else begin
      w_len = i_len;
    end
    w_accept = (r_state == ST_IDLE) && i_start;
  end

  // Frame sequencing; r_bit_cnt counts bits still to leave the line,
  // including the one currently driven.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_ser_out   <= 1'b0;
      r_ser_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_busy <= 1'b1;
            if (w_len != '0) begin
              r_state     <= ST_SHIFT;
              r_ser_out   <= i_data_in[DATA_W-1];
              r_ser_valid <= 1'b1;
              r_shift     <= {i_data_in[DATA_W-2:0], 1'b0};
              r_bit_cnt   <= w_len;
            end else begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          if (r_bit_cnt == LEN_W'(1)) begin
            r_state     <= ST_DONE;
            r_ser_out   <= 1'b0;
            r_ser_valid <= 1'b0;
            r_bit_cnt   <= '0;
            r_done      <= 1'b1;
          end else begin
            r_ser_out <= r_shift[DATA_W-1];
            r_shift   <= {r_shift[DATA_W-2:0], 1'b0};
            r_bit_cnt <= r_bit_cnt - LEN_W'(1);
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_ser_out   <= 1'b0;
          r_ser_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_done      <= 1'b0;
        end
      endcase
    end
  end

  seq_match_model #(
    .PATTERN (PATTERN),
    .CNT_W   (CNT_W),
    .OVERLAP (1'b1)
  ) u_model_ol (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clr     (w_accept),
    .i_bit_vld (r_ser_valid),
    .i_bit_in  (r_ser_out),
    .o_cnt     (o_exp_cnt_ol)
  );

  seq_match_model #(
    .PATTERN (PATTERN),
    .CNT_W   (CNT_W),
    .OVERLAP (1'b0)
  ) u_model_nol (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clr     (w_accept),
    .i_bit_vld (r_ser_valid),
    .i_bit_in  (r_ser_out),
    .o_cnt     (o_exp_cnt_nol)
  );

  assign o_ser_out   = r_ser_out;
  assign o_ser_valid = r_ser_valid;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

endmodule
